// File: rtl/sp_memory_pkg.sv
// rtl/sp_memory_pkg.sv - shared defaults, op encodings and FSM states for sp_memory
package sp_memory_pkg;

  localparam int SP_DATA_WIDTH = 16;
  localparam int SP_ADDR_WIDTH = 4;
  localparam int SP_DEPTH      = 16;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef enum logic {
    RESET = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/sp_memory_array.sv
// rtl/sp_memory_array.sv - word storage with asynchronous clear and a registered read port
module sp_memory_array #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;

  // Addresses beyond DEPTH wrap; a no-op when DEPTH fills the address space.
  always_comb idx = ADDR_WIDTH'(32'(addr) % DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[idx] <= wdata;
      if (re) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/sp_memory.sv
// rtl/sp_memory.sv - single-port memory with valid/ready handshake; SP_MEMORY_PARITY_EN adds parity and perr_o
module sp_memory
  import sp_memory_pkg::*;
#(
  parameter int DATA_WIDTH = SP_DATA_WIDTH,
  parameter int ADDR_WIDTH = SP_ADDR_WIDTH,
  parameter int DEPTH      = SP_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_en_i,
  input  logic                  valid_i,
`ifdef SP_MEMORY_PARITY_EN
  output logic                  perr_o,
`endif
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o
);

`ifdef SP_MEMORY_PARITY_EN
  localparam int STORE_W = DATA_WIDTH + 1;
`else
  localparam int STORE_W = DATA_WIDTH;
`endif

  state_t             state;
  logic               wr_xfer;
  logic               rd_xfer;
  logic [STORE_W-1:0] store_wdata;
  logic [STORE_W-1:0] store_rdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RESET;
      ready_o <= 1'b0;
    end else begin
      case (state)
        RESET: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr_xfer = valid_i && ready_o && (wr_rd_en_i == OP_WRITE);
    rd_xfer = valid_i && ready_o && (wr_rd_en_i == OP_READ);
  end

`ifdef SP_MEMORY_PARITY_EN
  // Even parity: the stored word including its parity bit always XORs to 0.
  always_comb store_wdata = {^wdata_i, wdata_i};
  // Derived only from the registered read word, so it changes only on read transfers.
  always_comb perr_o = ^store_rdata;
`else
  always_comb store_wdata = wdata_i;
`endif

  always_comb rdata_o = store_rdata[DATA_WIDTH-1:0];

  sp_memory_array #(
    .WIDTH     (STORE_W),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (clk_i),
    .rst  (rst_i),
    .we   (wr_xfer),
    .re   (rd_xfer),
    .addr (addr_i),
    .wdata(store_wdata),
    .rdata(store_rdata)
  );

endmodule

// File: tb/tb_sp_memory.sv
// tb/tb_sp_memory.sv - scoreboard bench for sp_memory; SP_MEMORY_PARITY_EN enables the parity scenario
module tb_sp_memory;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DP = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] wdata_i = '0;
  logic [AW-1:0] addr_i = '0;
  logic          wr_rd_en_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] rdata_o;
  logic          ready_o;
`ifdef SP_MEMORY_PARITY_EN
  logic          perr_o;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [DP];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd = '0;

  sp_memory dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wdata_i   (wdata_i),
    .addr_i    (addr_i),
    .wr_rd_en_i(wr_rd_en_i),
    .valid_i   (valid_i),
`ifdef SP_MEMORY_PARITY_EN
    .perr_o    (perr_o),
`endif
    .rdata_o   (rdata_o),
    .ready_o   (ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Called at a negedge; issues one request and returns at the next negedge.
  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    bit pushed;
    pushed = 0;
    valid_i = 1'b1; wr_rd_en_i = wr; addr_i = a; wdata_i = d;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL req_ready: ready_o=%b expected 1", ready_o);
    end
    if (wr) model[a] = d;
    else begin
      exp_q.push_back(model[a]);
      pushed = 1;
    end
    @(negedge clk_i);
    if (pushed) begin
      e = exp_q.pop_front();
      last_rd = e;
      checks++;
      if (rdata_o !== e) begin
        errors++;
        $display("FAIL read_data addr=%0d: rdata_o=%h expected %h", a, rdata_o, e);
      end
    end
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DP; i++) model[i] = '0;
    rst_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      checks++;
      if (rdata_o !== '0 || ready_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: rdata_o=%h ready_o=%b expected 0000/0", rdata_o, ready_o);
      end
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready_o=%b expected 0", ready_o);
    end
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready_o=%b expected 1", ready_o);
    end
  endtask

  task automatic test_write_read();
    req(1'b1, 4'd3, 16'hA5A5);
    req(1'b0, 4'd3, 16'h0000);
    idle_inputs();
  endtask

  task automatic test_idle_unwritten();
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b0; wr_rd_en_i = 1'b1;
      addr_i = 4'(i * 5); wdata_i = 16'(16'h1234 ^ (i * 16'h0F0F));
      @(negedge clk_i);
      checks++;
      if (rdata_o !== last_rd) begin
        errors++;
        $display("FAIL idle_hold: rdata_o=%h expected %h", rdata_o, last_rd);
      end
    end
    req(1'b0, 4'd3, 16'h0000);
    req(1'b0, 4'd7, 16'h0000);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) req(1'b1, 4'(k), 16'(k * 16'h1111));
    for (int k = 0; k < 16; k++) req(1'b0, 4'(k), 16'h0000);
    // Write then immediate read of the same word.
    req(1'b1, 4'd9, 16'hBEEF);
    req(1'b0, 4'd9, 16'h0000);
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    req(1'b0, 4'd15, 16'h0000);
    valid_i = 1'b1; wr_rd_en_i = 1'b1; addr_i = 4'd5; wdata_i = 16'hFFFF;
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (rdata_o !== '0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: rdata_o=%h ready_o=%b expected 0000/0", rdata_o, ready_o);
    end
    for (int i = 0; i < DP; i++) model[i] = '0;
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: ready_o=%b expected 1", ready_o);
    end
    req(1'b0, 4'd5, 16'h0000);
    req(1'b0, 4'd3, 16'h0000);
    idle_inputs();
  endtask

`ifdef SP_MEMORY_PARITY_EN
  task automatic test_parity();
    req(1'b1, 4'd2, 16'h0001);
    req(1'b1, 4'd4, 16'h0003);
    dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
    model[2] = 16'h0000;
    req(1'b0, 4'd2, 16'h0000);
    checks++;
    if (perr_o !== 1'b1) begin
      errors++;
      $display("FAIL parity_error: perr_o=%b expected 1", perr_o);
    end
    req(1'b0, 4'd4, 16'h0000);
    checks++;
    if (perr_o !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: perr_o=%b expected 0", perr_o);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_idle_unwritten();
    test_back_to_back();
    test_mid_reset();
`ifdef SP_MEMORY_PARITY_EN
    test_parity();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
